// File: rtl/btn_debounce_mode.sv
// Push-button front end: sync, debounce, press/release/long strobes
// and a small rate-select mode register for the LED blinker.
module btn_debounce_mode #(
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int LONG_PRESS_CYCLES = 27000000,
  parameter int ACTIVE_LOW        = 1,
  parameter int NUM_MODES         = 4,
  localparam int MODE_W           = $clog2(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              btn_i,
  output logic              btn_level_o,
  output logic              press_o,
  output logic              release_o,
  output logic              long_o,
  output logic [MODE_W-1:0] mode_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  localparam logic INACT = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);

  logic              sync1_q, sync2_q;
  logic [DW-1:0]     deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              seen_q, seen_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              pressed_raw;

  // Next-state: debounce, strobes, hold timer and mode update
  always_comb begin
    pressed_raw = sync2_q ^ INACT;
    deb_cnt_d   = deb_cnt_q;
    level_d     = level_q;
    if (pressed_raw == level_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      level_d   = pressed_raw;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end

    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;

    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HW'(1);
    end else begin
      hold_d = hold_q;
    end

    // A release landing on the firing cycle suppresses the long strobe
    long_d = level_q & level_d & (hold_q == HOLD_MAX) & ~seen_q;

    seen_d = seen_q;
    mode_d = mode_q;
    if (long_d) begin
      mode_d = '0;
      seen_d = 1'b1;
    end else if (release_d) begin
      if (!seen_q) begin
        mode_d = (mode_q == MODE_MAX) ? '0 : mode_q + MODE_W'(1);
      end
      seen_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q   <= INACT;
      sync2_q   <= INACT;
      deb_cnt_q <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      seen_q    <= 1'b0;
      mode_q    <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      seen_q    <= seen_d;
      mode_q    <= mode_d;
    end
  end

  assign btn_level_o = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign long_o      = long_q;
  assign mode_o      = mode_q;

endmodule

// File: tb/tb_btn_debounce_mode.sv
// Bench for btn_debounce_mode: directed plan plus random button
// activity compared cycle by cycle against a behavioural model.
module tb_btn_debounce_mode;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int NM   = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_i;
  logic       btn_level_o, press_o, release_o, long_o;
  logic [1:0] mode_o;

  btn_debounce_mode #(
    .DEBOUNCE_CYCLES(DEB),
    .LONG_PRESS_CYCLES(LONG),
    .ACTIVE_LOW(1),
    .NUM_MODES(NM)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .btn_i(btn_i),
    .btn_level_o(btn_level_o),
    .press_o(press_o),
    .release_o(release_o),
    .long_o(long_o),
    .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  logic m_s1, m_s2, m_lvl, m_press, m_rel, m_lng, m_fired;
  int   m_run, m_hi, m_mode;

  // tallies
  int cyc_n = 0;
  int n_press, n_rel, n_long, n_lvl;
  int press_at, rel_at, long_at;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model(input logic b, input logic r);
    logic praw, nl;
    if (!r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_lvl = 1'b0;
      m_press = 1'b0; m_rel = 1'b0; m_lng = 1'b0;
      m_fired = 1'b0; m_run = 0; m_hi = 0; m_mode = 0;
    end else begin
      praw = ~m_s2;
      nl = m_lvl;
      if (praw != m_lvl) begin
        m_run++;
        if (m_run == DEB) begin
          nl = praw;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_hi = m_lvl ? m_hi + 1 : 0;
      m_press = nl & ~m_lvl;
      m_rel = ~nl & m_lvl;
      m_lng = nl && (m_hi == LONG);
      if (m_lng) begin
        m_mode = 0;
        m_fired = 1'b1;
      end else if (m_rel) begin
        if (!m_fired) m_mode = (m_mode + 1) % NM;
        m_fired = 1'b0;
      end
      m_lvl = nl;
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic cyc(input logic b, input logic r);
    btn_i = b;
    rstn = r;
    @(posedge clk);
    model(b, r);
    #1;
    cyc_n++;
    chk("level", int'(btn_level_o), int'(m_lvl));
    chk("press", int'(press_o), int'(m_press));
    chk("release", int'(release_o), int'(m_rel));
    chk("long", int'(long_o), int'(m_lng));
    chk("mode", int'(mode_o), m_mode);
    if (press_o === 1'b1) begin n_press++; press_at = cyc_n; end
    if (release_o === 1'b1) begin n_rel++; rel_at = cyc_n; end
    if (long_o === 1'b1) begin n_long++; long_at = cyc_n; end
    if (btn_level_o === 1'b1) n_lvl++;
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) cyc(b, 1'b1);
  endtask

  task automatic clr();
    n_press = 0; n_rel = 0; n_long = 0; n_lvl = 0;
    press_at = -1; rel_at = -1; long_at = -1;
  endtask

  task automatic tap(input int lo, input int hi);
    run(1'b0, lo);
    run(1'b1, hi);
  endtask

  initial begin
    int e0, r0, len;
    logic b;
    btn_i = 1'b1;
    rstn = 1'b0;
    clr();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    run(1'b1, 50);
    chk("idle_mode", int'(mode_o), 0);
    chk("idle_strobes", n_press + n_rel + n_long + n_lvl, 0);

    // first clean press
    clr();
    e0 = cyc_n + 1;
    tap(10, 10);
    chk("press_lat", press_at - e0, DEB + 1);
    chk("rel_lat", rel_at - (e0 + 10), DEB + 1);
    chk("lvl_len", n_lvl, 10);
    chk("mode_1", int'(mode_o), 1);

    // four short presses: 2,3,0,1
    for (int k = 0; k < 4; k++) begin
      tap(10, 10);
      chk("mode_step", int'(mode_o), (2 + k) % NM);
    end

    // bounce shorter than the window
    clr();
    run(1'b0, 3); run(1'b1, 1); run(1'b0, 3); run(1'b1, 10);
    chk("glitch_strobes", n_press + n_rel + n_lvl, 0);
    chk("glitch_mode", int'(mode_o), 1);

    // long press from mode 2
    tap(10, 10);
    chk("mode_2", int'(mode_o), 2);
    clr();
    tap(40, 10);
    chk("long_cnt", n_long, 1);
    chk("long_lat", long_at - press_at, LONG);
    chk("long_rel", n_rel, 1);
    chk("long_mode", int'(mode_o), 0);

    // release on the firing cycle wins; one cycle more fires
    clr();
    tap(LONG, 10);
    chk("edge_nolong", n_long, 0);
    chk("edge_mode", int'(mode_o), 1);
    clr();
    tap(LONG + 1, 10);
    chk("edge_long", n_long, 1);
    chk("edge_mode0", int'(mode_o), 0);

    // reset while held
    tap(10, 10);
    run(1'b0, 10);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("rst_level", int'(btn_level_o), 0);
    chk("rst_mode", int'(mode_o), 0);
    clr();
    r0 = cyc_n + 1;
    run(1'b0, 12);
    chk("rst_press_lat", press_at - r0, DEB + 1);
    chk("rst_mode_after", int'(mode_o), 0);
    run(1'b1, 10);

    // random activity
    for (int it = 0; it < 200; it++) begin
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(18, 45);
      else len = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) cyc(b, 1'b0);
      run(b, len);
    end
    run(1'b1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout cycle=%0d", cyc_n);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
